ex_stage: RTL
=============

Name: ex_stage

Overview:
- Execute stage of the 5-stage pipeline.
- Consumes the registered 32-bit sign-extended immediate from the decode stage, together with the register-file operands and pc+4.
- Produces the registered EX/MEM result: ALU result, zero flag, branch target, and forwarded destination and control.
- Contains an iterative multiply/divide unit with HI/LO registers. It stalls the upstream pipeline while an operation is in progress.

Parameters:
- WIDTH, 32, datapath width
- MD_CYCLES, 32, iterations per multiply/divide (equals WIDTH)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- valid_in  in  1  ID/EX holds a valid instruction
- stall_in  in  1  downstream (MEM) hold; EX/MEM outputs must not change
- pc_plus4  in  32  pc+4 of the instruction
- rs_data  in  32  operand A
- rt_data  in  32  operand B (register)
- imm_ext  in  32  sign-extended immediate, aligned with rs_data/rt_data
- alu_src  in  1  0: B=rt_data, 1: B=imm_ext
- alu_op  in  4  ALU operation code (package)
- md_op  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO
- rd_in  in  5  destination register
- reg_write_in  in  1  writeback enable
- alu_result  out  32  registered result
- zero  out  1  registered (alu_result==0)
- branch_target  out  32  registered pc_plus4 + (imm_ext<<2)
- rd_out  out  5  registered rd_in
- reg_write_out  out  1  registered reg_write_in & accepted
- valid_out  out  1  registered: an instruction was accepted
- stall_out  out  1  combinational: upstream must hold ID/EX

Behaviour:
- Reset: rst is asynchronous and active-high; clk is the clock.
  - All registered outputs are 0, HI=LO=0, and the mul/div FSM is IDLE.
  - Asserting rst mid-operation aborts the multiply/divide with no HI/LO update.
- Accept condition: valid_in & !stall_in & !stall_out.
  - On accept, outputs update at the next clk edge (latency 1).
  - If valid_in is low and stall_in is low, valid_out and reg_write_out go to 0 and the other outputs hold.
  - If stall_in is high, all EX/MEM outputs hold.
- ALU operations. B is the mux of rt_data and imm_ext. Arithmetic wraps mod 2^32 with no overflow exception.
  - ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5
  - SLT=6 (signed compare), SLTU=7 (unsigned compare)
  - SLL=8, SRL=9, SRA=10: shift B by imm_ext[10:6]
  - LUI=11: B<<16
  - Codes 12-15 give result 0.
- branch_target is computed for every accepted instruction. It wraps at 2^32.
- md_op MFHI/MFLO: alu_result is HI/LO. If the mul/div unit is busy, stall_out=1 until it returns to IDLE; the move is then accepted.
- md_op MULT/MULTU/DIV/DIVU on accept:
  - Operands are latched and the FSM goes IDLE -> CALC.
  - reg_write_out=0 and alu_result=0 for that instruction; valid_out=1.
- FSM, IDLE -> CALC -> FIX -> IDLE:
  - CALC: MD_CYCLES cycles of shift-add (multiply) or restoring subtract (divide) on operand magnitudes.
  - FIX: applies the sign correction for the signed operations and writes HI/LO.
  - Multiply: HI/LO = the 64-bit product.
  - Divide: LO = quotient and HI = remainder. The remainder takes the sign of the dividend and the quotient truncates toward zero.
- Divide by zero: no exception. Result is LO=32'hFFFFFFFF, HI=rs_data, with the same latency.
- busy = (state != IDLE).
  - stall_out = valid_in & busy & (md_op != NONE).
  - Non-md instructions proceed while busy.
- Timing: an operation accepted at edge T has busy high for MD_CYCLES+1 cycles. HI/LO become readable at edge T+MD_CYCLES+2.
- Simultaneous events:
  - If stall_in=1 while the FSM runs, the FSM continues; stall_in only freezes the EX/MEM outputs.
  - A new md op while busy is held by stall_out, never dropped.

Decomposition:
- Shared package ex_pkg: ALU_* and MD_* codes, WIDTH default.
- Natural sub-module: mul_div_unit, containing the FSM, iteration counter, operand/HI/LO registers and the busy/start interface.
- ALU and output register stay in ex_stage.

Test Plan:
- ADDI path: alu_src=1, rs=5, imm_ext=32'hFFFFFFFD, ADD -> alu_result=2 and zero=0 one cycle later.
- SUB equal operands: rs=rt=7 -> alu_result=0 and zero=1.
- Branch target: pc_plus4=0x100, imm_ext=0xFFFFFFFF -> branch_target=0xFC.
- SLT vs SLTU: rs=0xFFFFFFFF, rt=1 -> SLT gives 1, SLTU gives 0.
- MULT rs=-3, rt=7:
  - stall_out rises on a following MFLO; busy lasts 33 cycles.
  - MFLO then gives 0xFFFFFFEB and MFHI gives 0xFFFFFFFF.
- DIV rs=-7, rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU by 0 with rs=9 -> LO=0xFFFFFFFF, HI=9.
- rst asserted during CALC -> HI=LO=0, stall_out=0 immediately.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared encodings and sizing for the execute stage and its multiply/divide unit.
package ex_pkg;

    localparam int WIDTH     = 32;
    localparam int MD_CYCLES = 32;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MFHI  = 3'd5;
    localparam logic [2:0] MD_MFLO  = 3'd6;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2
    } md_state_t;

    // True for the ops that launch an iterative multiply/divide.
    function automatic logic md_is_arith(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage; master is the pipeline side.
interface ex_stage_if #(parameter int WIDTH = 32);
    logic             valid_in;
    logic             stall_in;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic [WIDTH-1:0] imm_ext;
    logic             alu_src;
    logic [3:0]       alu_op;
    logic [2:0]       md_op;
    logic [4:0]       rd_in;
    logic             reg_write_in;
    logic [WIDTH-1:0] alu_result;
    logic             zero;
    logic [WIDTH-1:0] branch_target;
    logic [4:0]       rd_out;
    logic             reg_write_out;
    logic             valid_out;
    logic             stall_out;

    modport master (
        output valid_in, stall_in, pc_plus4, rs_data, rt_data, imm_ext,
               alu_src, alu_op, md_op, rd_in, reg_write_in,
        input  alu_result, zero, branch_target, rd_out, reg_write_out,
               valid_out, stall_out
    );

    modport slave (
        input  valid_in, stall_in, pc_plus4, rs_data, rt_data, imm_ext,
               alu_src, alu_op, md_op, rd_in, reg_write_in,
        output alu_result, zero, branch_target, rd_out, reg_write_out,
               valid_out, stall_out
    );
endinterface

// File: rtl/ex_stage_mul_div.sv
// Iterative multiply/divide on operand magnitudes with sign fix-up and HI/LO registers.
module mul_div_unit import ex_pkg::*; #(
    parameter int WIDTH     = ex_pkg::WIDTH,
    parameter int MD_CYCLES = ex_pkg::MD_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(MD_CYCLES);

    md_state_t        state_r, state_nx_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] opnd_r, acc_hi_r, acc_lo_r, hi_r, lo_r;
    logic             is_div_r, neg_res_r, neg_rem_r, div0_r;

    logic             signed_s, a_neg_s, b_neg_s, op_div_s;
    logic [WIDTH-1:0] a_mag_s, b_mag_s, quot_s, rem_s;
    logic [WIDTH:0]   mul_sum_s, div_shift_s, div_diff_s;
    logic [2*WIDTH-1:0] prod_s;

    assign signed_s    = (op == MD_MULT) || (op == MD_DIV);
    assign op_div_s    = (op == MD_DIV) || (op == MD_DIVU);
    assign a_neg_s     = signed_s & a[WIDTH-1];
    assign b_neg_s     = signed_s & b[WIDTH-1];
    assign a_mag_s     = a_neg_s ? -a : a;
    assign b_mag_s     = b_neg_s ? -b : b;
    assign mul_sum_s   = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    assign div_shift_s = {acc_hi_r, acc_lo_r[WIDTH-1]};
    assign div_diff_s  = div_shift_s - {1'b0, opnd_r};
    assign prod_s      = neg_res_r ? -{acc_hi_r, acc_lo_r} : {acc_hi_r, acc_lo_r};
    // A zero divisor leaves an all-ones quotient that must not be sign-corrected.
    assign quot_s      = div0_r ? {WIDTH{1'b1}} : (neg_res_r ? -acc_lo_r : acc_lo_r);
    assign rem_s       = neg_rem_r ? -acc_hi_r : acc_hi_r;

    assign busy = (state_r != MD_IDLE);
    assign hi   = hi_r;
    assign lo   = lo_r;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= MD_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            MD_IDLE: begin
                if (start) state_nx_s = MD_CALC;
                else       state_nx_s = MD_IDLE;
            end
            MD_CALC: begin
                if (cnt_r == CW'(MD_CYCLES - 1)) state_nx_s = MD_FIX;
                else                              state_nx_s = MD_CALC;
            end
            MD_FIX:  state_nx_s = MD_IDLE;
            default: state_nx_s = MD_IDLE;
        endcase
    end

    // Operand latch, shift-add / restoring-subtract iterations and HI/LO write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r     <= '0;
            opnd_r    <= '0;
            acc_hi_r  <= '0;
            acc_lo_r  <= '0;
            hi_r      <= '0;
            lo_r      <= '0;
            is_div_r  <= 1'b0;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            div0_r    <= 1'b0;
        end else begin
            case (state_r)
                MD_IDLE: begin
                    if (start) begin
                        cnt_r     <= '0;
                        acc_hi_r  <= '0;
                        opnd_r    <= op_div_s ? b_mag_s : a_mag_s;
                        acc_lo_r  <= op_div_s ? a_mag_s : b_mag_s;
                        is_div_r  <= op_div_s;
                        neg_res_r <= a_neg_s ^ b_neg_s;
                        neg_rem_r <= a_neg_s;
                        div0_r    <= op_div_s & (b == '0);
                    end
                end
                MD_CALC: begin
                    cnt_r <= cnt_r + 1'b1;
                    if (is_div_r) begin
                        if (!div_diff_s[WIDTH]) begin
                            acc_hi_r <= div_diff_s[WIDTH-1:0];
                            acc_lo_r <= {acc_lo_r[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi_r <= div_shift_s[WIDTH-1:0];
                            acc_lo_r <= {acc_lo_r[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_hi_r <= mul_sum_s[WIDTH:1];
                        acc_lo_r <= {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
                    end
                end
                MD_FIX: begin
                    if (is_div_r) begin
                        hi_r <= rem_s;
                        lo_r <= quot_s;
                    end else begin
                        hi_r <= prod_s[2*WIDTH-1:WIDTH];
                        lo_r <= prod_s[WIDTH-1:0];
                    end
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch target, mul/div issue and the EX/MEM pipeline register.
module ex_stage import ex_pkg::*; #(
    parameter int WIDTH     = ex_pkg::WIDTH,
    parameter int MD_CYCLES = ex_pkg::MD_CYCLES
) (
    input logic       clk,
    input logic       rst,
    ex_stage_if.slave ex
);
    logic [WIDTH-1:0] b_s, alu_s, res_s, hi_s, lo_s;
    logic [4:0]       sh_s;
    logic             busy_s, stall_s, accept_s, md_start_s;

    logic [WIDTH-1:0] alu_result_r, branch_target_r;
    logic [4:0]       rd_r;
    logic             zero_r, reg_write_r, valid_r;

    assign b_s        = ex.alu_src ? ex.imm_ext : ex.rt_data;
    assign sh_s       = ex.imm_ext[10:6];
    // Any HI/LO access waits for the unit; plain ALU ops flow past a busy unit.
    assign stall_s    = ex.valid_in & busy_s & (ex.md_op != MD_NONE);
    assign accept_s   = ex.valid_in & ~ex.stall_in & ~stall_s;
    assign md_start_s = accept_s & md_is_arith(ex.md_op);

    mul_div_unit #(.WIDTH(WIDTH), .MD_CYCLES(MD_CYCLES)) u_md (
        .clk   (clk),
        .rst   (rst),
        .start (md_start_s),
        .op    (ex.md_op),
        .a     (ex.rs_data),
        .b     (ex.rt_data),
        .busy  (busy_s),
        .hi    (hi_s),
        .lo    (lo_s)
    );

    // ALU operation decode.
    always_comb begin
        alu_s = '0;
        case (ex.alu_op)
            ALU_ADD:  alu_s = ex.rs_data + b_s;
            ALU_SUB:  alu_s = ex.rs_data - b_s;
            ALU_AND:  alu_s = ex.rs_data & b_s;
            ALU_OR:   alu_s = ex.rs_data | b_s;
            ALU_XOR:  alu_s = ex.rs_data ^ b_s;
            ALU_NOR:  alu_s = ~(ex.rs_data | b_s);
            ALU_SLT:  alu_s = {{(WIDTH-1){1'b0}}, ($signed(ex.rs_data) < $signed(b_s))};
            ALU_SLTU: alu_s = {{(WIDTH-1){1'b0}}, (ex.rs_data < b_s)};
            ALU_SLL:  alu_s = b_s << sh_s;
            ALU_SRL:  alu_s = b_s >> sh_s;
            ALU_SRA:  alu_s = $signed(b_s) >>> sh_s;
            ALU_LUI:  alu_s = {b_s[WIDTH-17:0], 16'h0000};
            default:  alu_s = '0;
        endcase
    end

    // Result select between ALU and HI/LO moves.
    always_comb begin
        res_s = alu_s;
        case (ex.md_op)
            MD_MFHI:  res_s = hi_s;
            MD_MFLO:  res_s = lo_s;
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: res_s = '0;
            default:  res_s = alu_s;
        endcase
    end

    // EX/MEM register; a downstream hold freezes every field.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_result_r    <= '0;
            zero_r          <= 1'b0;
            branch_target_r <= '0;
            rd_r            <= 5'd0;
            reg_write_r     <= 1'b0;
            valid_r         <= 1'b0;
        end else if (!ex.stall_in) begin
            if (accept_s) begin
                alu_result_r    <= res_s;
                zero_r          <= (res_s == '0);
                branch_target_r <= ex.pc_plus4 + {ex.imm_ext[WIDTH-3:0], 2'b00};
                rd_r            <= ex.rd_in;
                reg_write_r     <= ex.reg_write_in & ~md_is_arith(ex.md_op);
                valid_r         <= 1'b1;
            end else begin
                reg_write_r     <= 1'b0;
                valid_r         <= 1'b0;
            end
        end
    end

    assign ex.alu_result    = alu_result_r;
    assign ex.zero          = zero_r;
    assign ex.branch_target = branch_target_r;
    assign ex.rd_out        = rd_r;
    assign ex.reg_write_out = reg_write_r;
    assign ex.valid_out     = valid_r;
    assign ex.stall_out     = stall_s;

endmodule
